fu_cdb_arbiter: RTL and testbench

Completion-stage arbiter between the functional units (ALU, MULT, LOAD, BRANCH) and the common data bus. Each cycle it takes up to `FU_NUM` completion requests and grants up to `CDB_W` of them in round-robin order. Granted results are registered onto the CDB one cycle later, and ungranted FUs receive `bs_hazard` so they hold their output packet. It consumes each FU's `fum_complete_req` / `FU_COMPLETE_PACKET` and drives each FU's `bs_hazard` input.

---
 rtl/fu_cdb_arbiter_pkg.sv | 31 +++
 rtl/fu_cdb_arbiter_rr_multi_select.sv | 57 +++++
 rtl/fu_cdb_arbiter.sv | 89 ++++++++
 tb/tb_fu_cdb_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fu_cdb_arbiter_pkg.sv
// fu_cdb_arbiter_pkg
//   System-wide defaults, and the completion packet that travels from a
//   functional unit to the common data bus. Also holds the round-robin
//   pointer wrap helper that the arbiter uses.
package fu_cdb_arbiter_pkg;

  localparam int unsigned SYS_FU_NUM    = 4;
  localparam int unsigned SYS_CDB_WIDTH = 2;

  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned PR_IDX_W  = 6;
  localparam int unsigned XLEN      = 32;

  typedef struct packed {
    logic                 valid;
    logic                 halt;
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [PR_IDX_W-1:0]  dest_pr;
    logic [XLEN-1:0]      dest_value;
  } fu_complete_packet_t;

  localparam int unsigned PKT_W = $bits(fu_complete_packet_t);

  // Next round-robin start after the last grant. The wrap is an explicit
  // compare against n, so a non-power-of-two FU count never wraps at 2^PTR_W.
  function automatic int unsigned ptr_wrap_inc(input int unsigned last,
                                               input int unsigned n);
    return (last + 1 >= n) ? 0 : last + 1;
  endfunction

endpackage

// File: rtl/fu_cdb_arbiter_rr_multi_select.sv
// rr_multi_select
//   Combinational multi-grant round-robin picker. Scans requesters in the
//   order ptr, ptr+1, ... (mod FU_NUM) and grants the first CDB_W of them.
// Ports:
//   i_req        [FU_NUM]        request vector
//   i_ptr        [PTR_W]         highest-priority FU this cycle
//   o_grant      [FU_NUM]        one bit per granted FU
//   o_lane_valid [CDB_W]         lane j has a granted FU (fills from lane 0)
//   o_lane_idx   [CDB_W][PTR_W]  FU index feeding lane j
//   o_last_idx   [PTR_W]         index of the lowest-priority granted FU
module rr_multi_select
  import fu_cdb_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUM = SYS_FU_NUM,
  parameter int unsigned CDB_W  = SYS_CDB_WIDTH,
  parameter int unsigned PTR_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
  input  logic [FU_NUM-1:0]           i_req,
  input  logic [PTR_W-1:0]            i_ptr,
  output logic [FU_NUM-1:0]           o_grant,
  output logic [CDB_W-1:0]            o_lane_valid,
  output logic [CDB_W-1:0][PTR_W-1:0] o_lane_idx,
  output logic [PTR_W-1:0]            o_last_idx
);

  int unsigned      w_pos;
  int unsigned      w_cnt;
  logic [PTR_W-1:0] w_idx;

  // Walk the rotated request vector; each hit takes the next free lane.
  always_comb begin
    o_grant      = '0;
    o_lane_valid = '0;
    o_lane_idx   = '0;
    o_last_idx   = '0;
    w_pos        = 0;
    w_cnt        = 0;
    w_idx        = '0;
    for (int unsigned off = 0; off < FU_NUM; off++) begin
      w_pos = 32'(i_ptr) + off;
      if (w_pos >= FU_NUM) w_pos = w_pos - FU_NUM;
      w_idx = PTR_W'(w_pos);
      if (i_req[w_idx] && (w_cnt < CDB_W)) begin
        o_grant[w_idx] = 1'b1;
        for (int unsigned k = 0; k < CDB_W; k++) begin
          if (k == w_cnt) begin
            o_lane_valid[k] = 1'b1;
            o_lane_idx[k]   = w_idx;
          end
        end
        o_last_idx = w_idx;
        w_cnt      = w_cnt + 1;
      end
    end
  end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// fu_cdb_arbiter
//   Completion-stage arbiter: grants up to CDB_W of FU_NUM completing
//   functional units per cycle in round-robin order, registers the granted
//   packets onto the CDB one cycle later, and raises fu_hazard on every
//   requester that lost so it holds its packet.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   squash            pipeline flush; kills this cycle's grants
//   fu_complete_req   [FU_NUM]          FU i has a finished result
//   fu_out_pkt        [FU_NUM][PKT_W]   result packet of FU i
//   fu_hazard         [FU_NUM]          combinational; 1 = not granted, hold
//   cdb_valid         [CDB_W]           registered lane valid
//   cdb_pkt           [CDB_W][PKT_W]    registered lane packet (0 when idle)
module fu_cdb_arbiter
  import fu_cdb_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUM = SYS_FU_NUM,
  parameter int unsigned CDB_W  = SYS_CDB_WIDTH,
  parameter int unsigned PTR_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        squash,
  input  logic [FU_NUM-1:0]           fu_complete_req,
  input  logic [FU_NUM-1:0][PKT_W-1:0] fu_out_pkt,
  output logic [FU_NUM-1:0]           fu_hazard,
  output logic [CDB_W-1:0]            cdb_valid,
  output logic [CDB_W-1:0][PKT_W-1:0] cdb_pkt
);

  logic [PTR_W-1:0]            r_rr_ptr;
  logic [CDB_W-1:0]            r_cdb_valid;
  fu_complete_packet_t         r_cdb_pkt [CDB_W];

  logic [FU_NUM-1:0]           w_grant;
  logic [CDB_W-1:0]            w_lane_valid;
  logic [CDB_W-1:0][PTR_W-1:0] w_lane_idx;
  logic [PTR_W-1:0]            w_last_idx;
  logic [PTR_W-1:0]            w_next_ptr;

  rr_multi_select #(
    .FU_NUM (FU_NUM),
    .CDB_W  (CDB_W),
    .PTR_W  (PTR_W)
  ) u_sel (
    .i_req        (fu_complete_req),
    .i_ptr        (r_rr_ptr),
    .o_grant      (w_grant),
    .o_lane_valid (w_lane_valid),
    .o_lane_idx   (w_lane_idx),
    .o_last_idx   (w_last_idx)
  );

  assign w_next_ptr = PTR_W'(ptr_wrap_inc(32'(w_last_idx), FU_NUM));

  // Losers hold their packet; during flush or reset nobody is told to hold.
  always_comb begin
    fu_hazard = fu_complete_req & ~w_grant;
    if (rst || squash) fu_hazard = '0;
  end

  // Lane registers and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= '0;
      for (int unsigned k = 0; k < CDB_W; k++) r_cdb_pkt[k] <= '0;
    end else if (squash) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= '0;
      for (int unsigned k = 0; k < CDB_W; k++) r_cdb_pkt[k] <= '0;
    end else begin
      r_cdb_valid <= w_lane_valid;
      for (int unsigned k = 0; k < CDB_W; k++) begin
        r_cdb_pkt[k] <= w_lane_valid[k] ? fu_complete_packet_t'(fu_out_pkt[w_lane_idx[k]])
                                        : '0;
      end
      // Any grant sets lane 0, so it doubles as the "something granted" flag.
      if (w_lane_valid[0]) r_rr_ptr <= w_next_ptr;
    end
  end

  assign cdb_valid = r_cdb_valid;

  always_comb begin
    for (int unsigned k = 0; k < CDB_W; k++) cdb_pkt[k] = r_cdb_pkt[k];
  end

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Self-checking bench for fu_cdb_arbiter (FU_NUM=4, CDB_W=2): directed
// scenarios followed by constrained-random traffic against a reference model.
module tb_fu_cdb_arbiter;
  import fu_cdb_arbiter_pkg::*;

  localparam int unsigned NFU = 4;
  localparam int unsigned NL  = 2;

  logic                        clk;
  logic                        rst;
  logic                        squash;
  logic [NFU-1:0]              fu_complete_req;
  logic [NFU-1:0][PKT_W-1:0]   fu_out_pkt;
  logic [NFU-1:0]              fu_hazard;
  logic [NL-1:0]               cdb_valid;
  logic [NL-1:0][PKT_W-1:0]    cdb_pkt;

  fu_cdb_arbiter #(.FU_NUM(NFU), .CDB_W(NL), .PTR_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .squash          (squash),
    .fu_complete_req (fu_complete_req),
    .fu_out_pkt      (fu_out_pkt),
    .fu_hazard       (fu_hazard),
    .cdb_valid       (cdb_valid),
    .cdb_pkt         (cdb_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int checks     = 0;
  int miscompares = 0;

  fu_complete_packet_t tb_pkt [NFU];
  int                  m_ptr;
  logic [NFU-1:0]      last_haz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fu_complete_packet_t rand_pkt();
    fu_complete_packet_t p;
    p.valid      = 1'($urandom);
    p.halt       = 1'($urandom);
    p.rob_entry  = ROB_IDX_W'($urandom);
    p.dest_pr    = PR_IDX_W'($urandom);
    p.dest_value = XLEN'($urandom);
    return p;
  endfunction

  // Starts at posedge+1, ends at the following posedge+1.
  task automatic run_cycle(input logic [NFU-1:0] req, input logic sq, input string tag);
    int             order_q[$];
    logic [NFU-1:0] gmask;
    logic [NFU-1:0] exp_haz;
    logic [NL-1:0]  exp_v;
    int             idx;
    int             nxt;
    logic [63:0]    exp_p;

    fu_complete_req = req;
    squash          = sq;
    for (int i = 0; i < NFU; i++) fu_out_pkt[i] = tb_pkt[i];

    // Priority list: m_ptr, m_ptr+1, ... mod 4; first two requesters win.
    gmask = '0;
    if (!sq) begin
      for (int off = 0; off < NFU; off++) begin
        idx = (m_ptr + off) % NFU;
        if (((req >> idx) & 4'b1) != 4'b0 && order_q.size() < NL) begin
          order_q.push_back(idx);
          gmask = gmask | (4'b1 << idx);
        end
      end
    end
    exp_haz = sq ? 4'b0 : (req & ~gmask);
    if (sq) nxt = 0;
    else if (order_q.size() > 0) nxt = (order_q[order_q.size()-1] + 1) % NFU;
    else nxt = m_ptr;

    #1;
    chk({tag, "/hazard"}, 64'(fu_hazard), 64'(exp_haz));

    @(posedge clk);
    #1;
    exp_v = '0;
    for (int k = 0; k < order_q.size(); k++) exp_v[k] = 1'b1;
    chk({tag, "/cdb_valid"}, 64'(cdb_valid), 64'(exp_v));
    for (int k = 0; k < NL; k++) begin
      exp_p = (k < order_q.size()) ? 64'(tb_pkt[order_q[k]]) : 64'b0;
      chk($sformatf("%s/cdb_pkt%0d", tag, k), 64'(cdb_pkt[k]), exp_p);
    end
    chk({tag, "/rr_ptr"}, 64'(dut.r_rr_ptr), 64'(nxt));
    m_ptr    = nxt;
    last_haz = exp_haz;
    vectors++;
  endtask

  initial begin
    logic [NFU-1:0] req;
    logic           sq;

    rst = 1'b1;
    squash = 1'b0;
    m_ptr = 0;
    last_haz = '0;
    for (int i = 0; i < NFU; i++) tb_pkt[i] = rand_pkt();
    fu_complete_req = 4'b1111;
    for (int i = 0; i < NFU; i++) fu_out_pkt[i] = tb_pkt[i];
    #3;
    chk("reset/hazard", 64'(fu_hazard), 64'b0);
    chk("reset/cdb_valid", 64'(cdb_valid), 64'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fu_complete_req = '0;
    chk("reset/rr_ptr", 64'(dut.r_rr_ptr), 64'b0);

    // Single request from FU2.
    tb_pkt[2] = '0;
    tb_pkt[2].valid = 1'b1;
    tb_pkt[2].dest_value = 32'h8;
    tb_pkt[2].rob_entry = 5'd10;
    run_cycle(4'b0100, 1'b0, "single");
    chk("single/lane0_value", 64'(cdb_pkt[0][XLEN-1:0]), 64'h8);

    // Squash with three requesters; pointer returns to 0.
    run_cycle(4'b1011, 1'b1, "squash");

    // Full contention over two cycles.
    for (int i = 0; i < NFU; i++) tb_pkt[i] = rand_pkt();
    run_cycle(4'b1111, 1'b0, "full0");
    chk("full0/hazard_tbl", 64'(last_haz), 64'(4'b1100));
    run_cycle(4'b1100, 1'b0, "full1");

    // Move the pointer to 3, then wrap from FU3 to FU0.
    run_cycle(4'b0100, 1'b0, "to3");
    for (int i = 0; i < NFU; i++) tb_pkt[i] = rand_pkt();
    run_cycle(4'b1011, 1'b0, "wrap");
    chk("wrap/hazard_tbl", 64'(last_haz), 64'(4'b0010));

    // FU1 was held; it wins, pointer goes to 2, then an idle cycle.
    run_cycle(4'b0010, 1'b0, "hold");
    run_cycle(4'b0000, 1'b0, "idle");

    // Reset mid-operation with lanes valid, asserted between edges.
    run_cycle(4'b0011, 1'b0, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst/cdb_valid", 64'(cdb_valid), 64'b0);
    chk("midrst/cdb_pkt0", 64'(cdb_pkt[0]), 64'b0);
    chk("midrst/rr_ptr", 64'(dut.r_rr_ptr), 64'b0);
    chk("midrst/hazard", 64'(fu_hazard), 64'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ptr = 0;
    last_haz = '0;

    // Random traffic; hazarded FUs keep request and packet stable.
    for (int n = 0; n < 400; n++) begin
      req = 4'($urandom) | last_haz;
      for (int i = 0; i < NFU; i++)
        if (!last_haz[i]) tb_pkt[i] = rand_pkt();
      sq = ($urandom_range(0, 15) == 0);
      run_cycle(req, sq, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
